// File: rtl/onehot_select_seq.sv
`default_nettype none
// ============================================================================
// Module      : onehot_select_seq
// Description : Registered N-to-2^N one-hot selector with a slot sequencer.
//               The slot index can be loaded directly, or stepped up or down.
//               Stepping wraps at a programmable limit (LAST). The select
//               lines are registered, so they are glitch-free and follow a
//               command by exactly one clock.
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_select_seq #(
    parameter int ADDR_W  = 3,
    parameter int NUM_OUT = 8,   // must equal 2**ADDR_W
    parameter int LAST    = 7    // highest legal index, 0 <= LAST <= NUM_OUT-1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               en,
    input  logic               load,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic               step,
    input  logic               dir,
    output logic [NUM_OUT-1:0] out,
    output logic [ADDR_W-1:0]  idx,
    output logic               wrap,
    output logic               err
);

    // Wrap limit at index width. Every compare is made against this value
    // rather than relying on 2^ADDR_W overflow, so non-power-of-two slot
    // counts sequence correctly.
    localparam logic [ADDR_W-1:0] c_last = LAST[ADDR_W-1:0];

    logic [ADDR_W-1:0]  idx_q,  idx_d;
    logic [NUM_OUT-1:0] out_q,  out_d;
    logic               wrap_q, wrap_d;
    logic               err_q,  err_d;

    // Next index and event pulses: load beats step, step beats hold.
    always_comb begin
        idx_d  = idx_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        if (load) begin
            // A rejected load still swallows a concurrent step.
            if (load_addr <= c_last) begin
                idx_d = load_addr;
            end else begin
                err_d = 1'b1;
            end
        end else if (step) begin
            if (dir) begin
                if (idx_q == c_last) begin
                    idx_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                if (idx_q == '0) begin
                    idx_d  = c_last;
                    wrap_d = 1'b1;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
        end
    end

    // Decode from the index being registered on this same edge, so out and
    // idx always agree. load_addr reaches the decoder only when load is high,
    // which keeps out free of X from an idle address bus.
    always_comb begin
        out_d = '0;
        if (en) begin
            out_d = NUM_OUT'(1) << idx_d;
        end
    end

    // State and output registers. An asynchronous reset drops any pending pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idx_q  <= '0;
            out_q  <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            out_q  <= out_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign out  = out_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;
    assign err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_onehot_select_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_onehot_select_seq
// Description : Scoreboard bench for onehot_select_seq. Unit A has LAST=4 and
//               unit B has the default LAST=7. Each issued command queues its
//               expected response, and a per-unit monitor compares it one
//               edge later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_onehot_select_seq;

    typedef struct {
        string      name;
        logic [7:0] out;
        logic [2:0] idx;
        logic       wrap;
        logic       err;
    } exp_t;

    logic       clock;
    logic       reset_n;

    logic       a_en, a_load, a_step, a_dir;
    logic [2:0] a_addr;
    logic [7:0] a_out;
    logic [2:0] a_idx;
    logic       a_wrap, a_err;

    logic       b_en, b_load, b_step, b_dir;
    logic [2:0] b_addr;
    logic [7:0] b_out;
    logic [2:0] b_idx;
    logic       b_wrap, b_err;

    exp_t qa[$];
    exp_t qb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    onehot_select_seq #(.ADDR_W(3), .NUM_OUT(8), .LAST(4)) u_a (
        .clock     (clock),
        .reset_n   (reset_n),
        .en        (a_en),
        .load      (a_load),
        .load_addr (a_addr),
        .step      (a_step),
        .dir       (a_dir),
        .out       (a_out),
        .idx       (a_idx),
        .wrap      (a_wrap),
        .err       (a_err)
    );

    onehot_select_seq #(.ADDR_W(3), .NUM_OUT(8), .LAST(7)) u_b (
        .clock     (clock),
        .reset_n   (reset_n),
        .en        (b_en),
        .load      (b_load),
        .load_addr (b_addr),
        .step      (b_step),
        .dir       (b_dir),
        .out       (b_out),
        .idx       (b_idx),
        .wrap      (b_wrap),
        .err       (b_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Direct comparison, used for the asynchronous reset checks.
    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, got, want);
        end
    endtask

    // Issue one command to unit A at the falling edge and queue its response.
    task automatic drv_a(input logic e, input logic l, input logic [2:0] ad,
                         input logic s, input logic d, input string nm,
                         input logic [7:0] xo, input logic [2:0] xi,
                         input logic xw, input logic xe);
        exp_t t;
        @(negedge clock);
        a_en = e; a_load = l; a_addr = ad; a_step = s; a_dir = d;
        t.name = nm; t.out = xo; t.idx = xi; t.wrap = xw; t.err = xe;
        qa.push_back(t);
    endtask

    task automatic drv_b(input logic e, input logic l, input logic [2:0] ad,
                         input logic s, input logic d, input string nm,
                         input logic [7:0] xo, input logic [2:0] xi,
                         input logic xw, input logic xe);
        exp_t t;
        @(negedge clock);
        b_en = e; b_load = l; b_addr = ad; b_step = s; b_dir = d;
        t.name = nm; t.out = xo; t.idx = xi; t.wrap = xw; t.err = xe;
        qb.push_back(t);
    endtask

    // Monitor A: compare each queued expectation just after the edge it covers.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            n_cmp++;
            if (a_out !== e.out || a_idx !== e.idx || a_wrap !== e.wrap || a_err !== e.err) begin
                n_bad++;
                $display("FAIL A:%s got out=%h idx=%0d wrap=%b err=%b, expected out=%h idx=%0d wrap=%b err=%b",
                         e.name, a_out, a_idx, a_wrap, a_err, e.out, e.idx, e.wrap, e.err);
            end
        end
    end

    // Monitor B: same as monitor A, for unit B.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (qb.size() > 0) begin
            e = qb.pop_front();
            n_cmp++;
            if (b_out !== e.out || b_idx !== e.idx || b_wrap !== e.wrap || b_err !== e.err) begin
                n_bad++;
                $display("FAIL B:%s got out=%h idx=%0d wrap=%b err=%b, expected out=%h idx=%0d wrap=%b err=%b",
                         e.name, b_out, b_idx, b_wrap, b_err, e.out, e.idx, e.wrap, e.err);
            end
        end
    end

    initial begin
        reset_n = 1'b1;
        a_en = 1'b1; a_load = 1'b0; a_addr = 3'd0; a_step = 1'b0; a_dir = 1'b0;
        b_en = 1'b1; b_load = 1'b0; b_addr = 3'd0; b_step = 1'b0; b_dir = 1'b0;

        // Asynchronous reset before any clock edge.
        #1 reset_n = 1'b0;
        #2;
        check("reset_a_out",  {8'h00, a_out}, 16'h0000);
        check("reset_a_idx",  {13'h0, a_idx}, 16'h0000);
        check("reset_a_flag", {14'h0, a_wrap, a_err}, 16'h0000);
        check("reset_b_out",  {8'h00, b_out}, 16'h0000);
        #4 reset_n = 1'b1;

        // Release with en=1 and no command: slot 0 selected.
        drv_a(1, 0, 3'd0, 0, 0, "idle_after_reset", 8'h01, 3'd0, 0, 0);

        // Step up through the wrap at LAST=4.
        drv_a(1, 1, 3'd3, 0, 0, "load3",     8'h08, 3'd3, 0, 0);
        drv_a(1, 0, 3'd0, 1, 1, "up_to4",    8'h10, 3'd4, 0, 0);
        drv_a(1, 0, 3'd0, 1, 1, "up_wrap",   8'h01, 3'd0, 1, 0);
        drv_a(1, 0, 3'd0, 1, 1, "up_to1",    8'h02, 3'd1, 0, 0);

        // Step down through the wrap at 0.
        drv_a(1, 1, 3'd0, 0, 0, "load0",     8'h01, 3'd0, 0, 0);
        drv_a(1, 0, 3'd0, 1, 0, "dn_wrap",   8'h10, 3'd4, 1, 0);
        drv_a(1, 0, 3'd0, 1, 0, "dn_to3",    8'h08, 3'd3, 0, 0);

        // Rejected loads hold the index and swallow a concurrent step.
        drv_a(1, 1, 3'd2, 0, 0, "load2",     8'h04, 3'd2, 0, 0);
        drv_a(1, 1, 3'd6, 1, 1, "rej6_step", 8'h04, 3'd2, 0, 1);
        drv_a(1, 0, 3'd0, 0, 0, "err_clear", 8'h04, 3'd2, 0, 0);
        drv_a(1, 1, 3'd5, 0, 0, "rej5",      8'h04, 3'd2, 0, 1);
        drv_a(1, 1, 3'd4, 0, 0, "load_last", 8'h10, 3'd4, 0, 0);

        // Enable masking: the index keeps sequencing while out stays low.
        drv_a(0, 1, 3'd0, 0, 0, "mask_load0", 8'h00, 3'd0, 0, 0);
        drv_a(0, 0, 3'd0, 1, 1, "mask_up1",   8'h00, 3'd1, 0, 0);
        drv_a(0, 0, 3'd0, 1, 1, "mask_up2",   8'h00, 3'd2, 0, 0);
        drv_a(1, 0, 3'd0, 1, 1, "unmask_up3", 8'h08, 3'd3, 0, 0);
        drv_a(1, 0, 3'd0, 0, 0, "hold3",      8'h08, 3'd3, 0, 0);

        // Reset asserted while a wrap pulse is showing.
        drv_a(1, 1, 3'd4, 0, 0, "pre_wrap",   8'h10, 3'd4, 0, 0);
        drv_a(1, 0, 3'd0, 1, 1, "wrap_pend",  8'h01, 3'd0, 1, 0);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("midreset_a_out",  {8'h00, a_out}, 16'h0000);
        check("midreset_a_idx",  {13'h0, a_idx}, 16'h0000);
        check("midreset_a_wrap", {15'h0, a_wrap}, 16'h0000);
        reset_n = 1'b1;
        drv_a(1, 0, 3'd0, 0, 0, "after_midreset", 8'h01, 3'd0, 0, 0);
        drv_a(1, 0, 3'd0, 1, 0, "dn_wrap2",       8'h10, 3'd4, 1, 0);

        // Unit B (LAST=7): decode sweep over every slot.
        for (int i = 0; i < 8; i++) begin
            drv_b(1, 1, 3'(i), 0, 0, $sformatf("sweep%0d", i), 8'h01 << i, 3'(i), 0, 0);
        end
        drv_b(1, 0, 3'd0, 1, 1, "b_up_wrap", 8'h01, 3'd0, 1, 0);
        drv_b(1, 0, 3'd0, 1, 0, "b_dn_wrap", 8'h80, 3'd7, 1, 0);
        drv_b(1, 0, 3'd0, 1, 0, "b_dn_6",    8'h40, 3'd6, 0, 0);
        drv_b(1, 0, 3'd0, 0, 0, "b_idle",    8'h40, 3'd6, 0, 0);

        // Drain the scoreboard within a bounded number of cycles.
        for (int k = 0; k < 5; k++) begin
            if (qa.size() != 0 || qb.size() != 0) begin
                @(posedge clock);
                #2;
            end
        end
        if (qa.size() != 0 || qb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d/%0d expectations left, expected 0/0", qa.size(), qb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
